// File: rtl/cond_unit.sv
// Execute-stage condition unit: holds the NZCV status register and a one-entry
// shadow copy, and decides whether the instruction in E executes.
module cond_unit #(
  parameter logic [3:0] RST_FLAGS = 4'b0000,
  parameter logic [3:0] RST_SAVED = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       flush,
  input  logic [3:0] Cond,
  input  logic [1:0] FlagWrite,
  input  logic       N,
  input  logic       Z,
  input  logic       C,
  input  logic       V,
  input  logic       save,
  input  logic       restore,
  output logic       CondEx,
  output logic [3:0] Flags,
  output logic [3:0] SavedFlags
);

  logic [3:0] flags_q, flags_d;
  logic [3:0] saved_q, saved_d;
  logic       fn, fz, fc, fv;
  logic       cond_true;

  assign {fn, fz, fc, fv} = flags_q;

  // Decode uses registered flags only; results from the flag generator are not forwarded.
  always_comb begin
    cond_true = 1'b0;
    case (Cond)
      4'h0: cond_true = fz;
      4'h1: cond_true = ~fz;
      4'h2: cond_true = fc;
      4'h3: cond_true = ~fc;
      4'h4: cond_true = fn;
      4'h5: cond_true = ~fn;
      4'h6: cond_true = fv;
      4'h7: cond_true = ~fv;
      4'h8: cond_true = fc & ~fz;
      4'h9: cond_true = ~fc | fz;
      4'hA: cond_true = (fn == fv);
      4'hB: cond_true = (fn != fv);
      4'hC: cond_true = ~fz & (fn == fv);
      4'hD: cond_true = fz | (fn != fv);
      4'hE: cond_true = 1'b1;
      4'hF: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  assign CondEx = cond_true & ~flush;

  // save reads the pre-edge flags, so save+restore swaps the two registers.
  always_comb begin
    flags_d = flags_q;
    saved_d = saved_q;
    if (!stall) begin
      if (save) begin
        saved_d = flags_q;
      end
      if (restore) begin
        flags_d = saved_q;
      end else begin
        if (CondEx && FlagWrite[1]) begin
          flags_d[3] = N;
          flags_d[2] = Z;
        end
        if (CondEx && FlagWrite[0]) begin
          flags_d[1] = C;
          flags_d[0] = V;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= RST_FLAGS;
      saved_q <= RST_SAVED;
    end else begin
      flags_q <= flags_d;
      saved_q <= saved_d;
    end
  end

  assign Flags      = flags_q;
  assign SavedFlags = saved_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: a reference model pushes expected register
// state per edge onto a scoreboard; each scenario task pops and compares it.
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic       stall;
  logic       flush;
  logic [3:0] Cond;
  logic [1:0] FlagWrite;
  logic       N, Z, C, V;
  logic       save;
  logic       restore;
  logic       CondEx;
  logic [3:0] Flags;
  logic [3:0] SavedFlags;

  cond_unit #(
    .RST_FLAGS(4'b0000),
    .RST_SAVED(4'b0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .Cond      (Cond),
    .FlagWrite (FlagWrite),
    .N         (N),
    .Z         (Z),
    .C         (C),
    .V         (V),
    .save      (save),
    .restore   (restore),
    .CondEx    (CondEx),
    .Flags     (Flags),
    .SavedFlags(SavedFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] f;
    logic [3:0] s;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [3:0] m_flags;
  logic [3:0] m_saved;
  int         vectors;
  int         miscompares;

  // Reference condition table written directly from the ARM condition list.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cc;
      4'h3: return !cc;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cc && !z;
      4'h9: return !cc || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic rst, input logic stl, input logic fl,
                       input logic [3:0] cnd, input logic [1:0] fw,
                       input logic [3:0] nzcv, input logic sv, input logic rs);
    reset = rst; stall = stl; flush = fl; Cond = cnd; FlagWrite = fw;
    {N, Z, C, V} = nzcv; save = sv; restore = rs;
  endtask

  // Advance one edge with the currently driven inputs, pushing the model's prediction.
  task automatic tick();
    exp_t       x;
    logic       ce;
    logic [3:0] nf, ns;
    nf = m_flags;
    ns = m_saved;
    if (reset) begin
      nf = 4'b0000;
      ns = 4'b0000;
    end else if (!stall) begin
      ce = cond_eval(Cond, m_flags) && !flush;
      if (save) ns = m_flags;
      if (restore) nf = m_saved;
      else begin
        if (ce && FlagWrite[1]) nf[3:2] = {N, Z};
        if (ce && FlagWrite[0]) nf[1:0] = {C, V};
      end
    end
    x.f = nf;
    x.s = ns;
    sb.push_back(x);
    @(posedge clk);
    #1;
    m_flags = nf;
    m_saved = ns;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 4'hE, 2'b00, 4'b0000, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    e = sb.pop_front();
    vectors++;
    if ({Flags, SavedFlags} !== {e.f, e.s}) begin
      miscompares++;
      $display("FAIL reset_regs: got %b/%b want %b/%b", Flags, SavedFlags, e.f, e.s);
    end
    vectors++;
    if ({Flags, SavedFlags} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_value: got %b/%b want 0000/0000", Flags, SavedFlags);
    end
    vectors++;
    if (CondEx !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_al: CondEx got %b want 1", CondEx);
    end
    Cond = 4'h0;
    #1;
    vectors++;
    if (CondEx !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_eq: CondEx got %b want 0", CondEx);
    end
    $display("test_reset: Flags=%b SavedFlags=%b", Flags, SavedFlags);
  endtask

  task automatic test_flag_write();
    logic [3:0] conds [3] = '{4'h0, 4'h8, 4'hF};
    logic       wants [3] = '{1'b1, 1'b0, 1'b0};
    drive(1'b0, 1'b0, 1'b0, 4'hE, 2'b11, 4'b0110, 1'b0, 1'b0);
    tick();
    FlagWrite = 2'b00;
    e = sb.pop_front();
    vectors++;
    if (Flags !== 4'b0110 || {Flags, SavedFlags} !== {e.f, e.s}) begin
      miscompares++;
      $display("FAIL write_al: got %b/%b want 0110/%b", Flags, SavedFlags, e.s);
    end
    for (int i = 0; i < 3; i++) begin
      Cond = conds[i];
      #1;
      vectors++;
      if (CondEx !== wants[i]) begin
        miscompares++;
        $display("FAIL cond_%h: CondEx got %b want %b", conds[i], CondEx, wants[i]);
      end
    end
    $display("test_flag_write: Flags=%b", Flags);
  endtask

  task automatic test_cond_false();
    drive(1'b0, 1'b0, 1'b0, 4'h1, 2'b11, 4'b1001, 1'b0, 1'b0);
    #1;
    vectors++;
    if (CondEx !== 1'b0) begin
      miscompares++;
      $display("FAIL ne_false: CondEx got %b want 0", CondEx);
    end
    tick();
    e = sb.pop_front();
    vectors++;
    if (Flags !== 4'b0110 || Flags !== e.f) begin
      miscompares++;
      $display("FAIL ne_nowrite: Flags got %b want 0110", Flags);
    end
    drive(1'b0, 1'b0, 1'b0, 4'hE, 2'b01, 4'b1001, 1'b0, 1'b0);
    tick();
    e = sb.pop_front();
    vectors++;
    if (Flags !== 4'b0101 || Flags !== e.f) begin
      miscompares++;
      $display("FAIL cv_only: Flags got %b want 0101", Flags);
    end
    $display("test_cond_false: Flags=%b", Flags);
  endtask

  task automatic test_signed();
    logic [3:0] conds [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    logic       wants [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    drive(1'b0, 1'b0, 1'b0, 4'hE, 2'b11, 4'b1000, 1'b0, 1'b0);
    tick();
    FlagWrite = 2'b00;
    e = sb.pop_front();
    vectors++;
    if (Flags !== 4'b1000 || Flags !== e.f) begin
      miscompares++;
      $display("FAIL set_1000: Flags got %b want 1000", Flags);
    end
    for (int i = 0; i < 4; i++) begin
      Cond = conds[i];
      #1;
      vectors++;
      if (CondEx !== wants[i]) begin
        miscompares++;
        $display("FAIL signed_%h: CondEx got %b want %b", conds[i], CondEx, wants[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 4'hE, 2'b11, 4'b1001, 1'b0, 1'b0);
    tick();
    e = sb.pop_front();
    FlagWrite = 2'b00;
    Cond = 4'hA;
    #1;
    vectors++;
    if (CondEx !== 1'b1 || Flags !== e.f) begin
      miscompares++;
      $display("FAIL ge_1001: CondEx got %b want 1 (Flags %b)", CondEx, Flags);
    end
    Cond = 4'hB;
    #1;
    vectors++;
    if (CondEx !== 1'b0) begin
      miscompares++;
      $display("FAIL lt_1001: CondEx got %b want 0", CondEx);
    end
    $display("test_signed: Flags=%b", Flags);
  endtask

  task automatic test_swap();
    drive(1'b0, 1'b0, 1'b0, 4'hE, 2'b11, 4'b1100, 1'b0, 1'b0);
    tick();
    void'(sb.pop_front());
    // save with a simultaneous write: shadow takes the old value
    drive(1'b0, 1'b0, 1'b0, 4'hE, 2'b11, 4'b0011, 1'b1, 1'b0);
    tick();
    e = sb.pop_front();
    vectors++;
    if ({Flags, SavedFlags} !== 8'b0011_1100 || {Flags, SavedFlags} !== {e.f, e.s}) begin
      miscompares++;
      $display("FAIL save_write: got %b/%b want 0011/1100", Flags, SavedFlags);
    end
    drive(1'b0, 1'b0, 1'b0, 4'hE, 2'b11, 4'b1111, 1'b1, 1'b1);
    tick();
    e = sb.pop_front();
    vectors++;
    if ({Flags, SavedFlags} !== 8'b1100_0011 || {Flags, SavedFlags} !== {e.f, e.s}) begin
      miscompares++;
      $display("FAIL swap: got %b/%b want 1100/0011", Flags, SavedFlags);
    end
    drive(1'b0, 1'b1, 1'b0, 4'hE, 2'b11, 4'b1111, 1'b1, 1'b1);
    tick();
    e = sb.pop_front();
    vectors++;
    if ({Flags, SavedFlags} !== 8'b1100_0011 || {Flags, SavedFlags} !== {e.f, e.s}) begin
      miscompares++;
      $display("FAIL stall_hold: got %b/%b want 1100/0011", Flags, SavedFlags);
    end
    $display("test_swap: Flags=%b SavedFlags=%b", Flags, SavedFlags);
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b0, 1'b1, 4'hE, 2'b11, 4'b1111, 1'b0, 1'b0);
    #1;
    vectors++;
    if (CondEx !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_condex: CondEx got %b want 0", CondEx);
    end
    tick();
    e = sb.pop_front();
    vectors++;
    if (Flags !== 4'b1100 || {Flags, SavedFlags} !== {e.f, e.s}) begin
      miscompares++;
      $display("FAIL flush_hold: got %b/%b want 1100/%b", Flags, SavedFlags, e.s);
    end
    drive(1'b0, 1'b0, 1'b1, 4'hE, 2'b11, 4'b1111, 1'b1, 1'b0);
    tick();
    e = sb.pop_front();
    vectors++;
    if ({Flags, SavedFlags} !== 8'b1100_1100 || {Flags, SavedFlags} !== {e.f, e.s}) begin
      miscompares++;
      $display("FAIL flush_save: got %b/%b want 1100/1100", Flags, SavedFlags);
    end
    drive(1'b1, 1'b0, 1'b0, 4'hE, 2'b00, 4'b0000, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    restore = 1'b0;
    e = sb.pop_front();
    vectors++;
    if ({Flags, SavedFlags} !== 8'h00 || {Flags, SavedFlags} !== {e.f, e.s}) begin
      miscompares++;
      $display("FAIL reset_restore: got %b/%b want 0000/0000", Flags, SavedFlags);
    end
    $display("test_flush: Flags=%b SavedFlags=%b", Flags, SavedFlags);
  endtask

  task automatic test_back_to_back();
    logic ce_want;
    for (int i = 0; i < 120; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
      #1;
      ce_want = cond_eval(Cond, m_flags) && !flush;
      vectors++;
      if (CondEx !== ce_want) begin
        miscompares++;
        $display("FAIL b2b_condex[%0d]: Cond=%h Flags=%b got %b want %b",
                 i, Cond, Flags, CondEx, ce_want);
      end
      tick();
      e = sb.pop_front();
      vectors++;
      if ({Flags, SavedFlags} !== {e.f, e.s}) begin
        miscompares++;
        $display("FAIL b2b_regs[%0d]: got %b/%b want %b/%b", i, Flags, SavedFlags, e.f, e.s);
      end
    end
    $display("test_back_to_back: 120 cycles, Flags=%b SavedFlags=%b", Flags, SavedFlags);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m_flags = 4'b0000;
    m_saved = 4'b0000;
    drive(1'b0, 1'b0, 1'b0, 4'hE, 2'b00, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_flag_write();
    test_cond_false();
    test_signed();
    test_swap();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
